// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// Adds two WIDTH-bit operands LSB-first, one bit per clock, using two
// half-adder cells and a carry flop. A requester raises start while the
// block is idle; the block reports busy for the whole operation and a
// one-cycle done pulse when sum/cout are final. The result is then held
// until the next accepted start.

// Single-bit half adder: s = x ^ y, c = x & y.
module halfadder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Handshake: start is sampled only while IDLE (busy=0); the edge that
    // samples it captures a/b and starts the operation. busy is high from
    // the next cycle through the DONE cycle, and start is ignored while
    // busy. done is high for exactly one cycle (the DONE state); sum and
    // cout are final from then on and hold until the next accepted start.

    // Bit counter wide enough to hold WIDTH; it indexes the bit being
    // processed in RUN, so the last bit is the one seen at WIDTH-1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Current FSM state; kept as a named enum so checkers can bind to it
    // hierarchically (u_dut.state).
    state_t state;

    // Operand shift registers: bit 0 is the bit being added this cycle.
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    // Carry into the current bit position.
    logic             cy;
    // Index of the bit being processed during RUN.
    logic [CNT_W-1:0] cnt;

    // Half-adder datapath nets.
    logic             p;        // propagate: sa[0] ^ sb[0]
    logic             g;        // generate:  sa[0] & sb[0]
    logic             s_bit;    // sum bit for this position
    logic             t;        // carry through the propagate path
    logic             cy_next;  // carry into the next position

    // Sum register after inserting this cycle's bit at the MSB.
    logic [WIDTH-1:0] sum_shift;

    halfadder u_ha_gen (
        .x (sa[0]),
        .y (sb[0]),
        .s (p),
        .c (g)
    );

    halfadder u_ha_carry (
        .x (p),
        .y (cy),
        .s (s_bit),
        .c (t)
    );

    assign cy_next = g | t;

    // Shift the sum right and drop the new bit in at the top; after WIDTH
    // shifts the first bit computed has walked down to position 0. Written
    // as shift-then-overwrite so it also holds for WIDTH=1.
    always_comb begin
        sum_shift            = sum >> 1;
        sum_shift[WIDTH-1]   = s_bit;
    end

    // Control FSM and all registered datapath/output state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        // Capture operands; later changes on a/b are not seen.
                        sa    <= a;
                        sb    <= b;
                        cy    <= 1'b0;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cy  <= cy_next;
                    sum <= sum_shift;
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        // Last bit: its carry-out is the final cout.
                        cout  <= cy_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // Result is final here; start is not sampled.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: one WIDTH=8 and one WIDTH=1 instance driven
// by a directed sequence, with a scoreboard that checks every done pulse.
module tb_serial_adder_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int done8_cnt = 0;
  int done1_cnt = 0;

  logic [8:0] exp8_q[$];
  logic [1:0] exp1_q[$];
  logic [8:0] e8;
  logic [1:0] e1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // ---------------- scoreboards ----------------
  // Every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      done8_cnt++;
      if (exp8_q.size() == 0) begin
        check("sb8_unexpected_done", 16'd1, 16'd0);
      end else begin
        e8 = exp8_q.pop_front();
        check("sb8_result", {7'd0, cout8, sum8}, {7'd0, e8});
      end
    end
    if (rst_n && done1) begin
      done1_cnt++;
      if (exp1_q.size() == 0) begin
        check("sb1_unexpected_done", 16'd1, 16'd0);
      end else begin
        e1 = exp1_q.pop_front();
        check("sb1_result", {14'd0, cout1, sum1}, {14'd0, e1});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call #1 after a rising edge. Runs one WIDTH=8 addition and checks the
  // busy/done timing edge by edge plus the held result afterwards.
  task automatic add8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] expv;
    expv = {1'b0, x} + {1'b0, y};
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    exp8_q.push_back(expv);
    @(posedge clk);             // E0: start accepted
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));  // must not disturb the operation
    b8 = 8'($urandom_range(0, 255));
    check("add8_busy_e0", {15'd0, busy8}, 16'd1);
    check("add8_done_e0", {15'd0, done8}, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check("add8_busy_run", {15'd0, busy8}, 16'd1);
      check("add8_done_timing", {15'd0, done8}, (k == 8) ? 16'd1 : 16'd0);
    end
    @(posedge clk);             // E9: back to idle
    #1;
    check("add8_busy_idle", {15'd0, busy8}, 16'd0);
    check("add8_done_idle", {15'd0, done8}, 16'd0);
    check("add8_held", {7'd0, cout8, sum8}, {7'd0, expv});
  endtask

  // Same for the WIDTH=1 instance: RUN is one cycle, done after E1.
  task automatic add1(input logic x, input logic y);
    logic [1:0] expv;
    expv = {1'b0, x} + {1'b0, y};
    a1 = x;
    b1 = y;
    start1 = 1'b1;
    exp1_q.push_back(expv);
    @(posedge clk);             // E0
    #1;
    start1 = 1'b0;
    a1 = ~a1;
    b1 = ~b1;
    check("add1_busy_e0", {15'd0, busy1}, 16'd1);
    check("add1_done_e0", {15'd0, done1}, 16'd0);
    @(posedge clk);             // E1: last (only) bit processed
    #1;
    check("add1_busy_e1", {15'd0, busy1}, 16'd1);
    check("add1_done_e1", {15'd0, done1}, 16'd1);
    @(posedge clk);             // E2: idle
    #1;
    check("add1_busy_idle", {15'd0, busy1}, 16'd0);
    check("add1_done_idle", {15'd0, done1}, 16'd0);
    check("add1_held", {14'd0, cout1, sum1}, {14'd0, expv});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    rst_n  = 1'b0;
    start8 = 1'b0;
    a8     = 8'h00;
    b8     = 8'h00;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst8_busy", {15'd0, busy8}, 16'd0);
    check("rst8_done", {15'd0, done8}, 16'd0);
    check("rst8_result", {7'd0, cout8, sum8}, 16'd0);
    check("rst1_result", {13'd0, busy1, cout1, sum1}, 16'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic additions and carry boundaries
    add8(8'h5A, 8'h3C);
    add8(8'hFF, 8'h01);
    add8(8'hFF, 8'hFF);
    add8(8'h00, 8'h00);

    // Result holds across idle cycles with start low
    idle_cycles(3);
    check("hold_idle", {7'd0, cout8, sum8}, 16'h0000);

    // start pulses during RUN and DONE are ignored
    d0 = done8_cnt;
    a8 = 8'h12;
    b8 = 8'h34;
    start8 = 1'b1;
    exp8_q.push_back(9'h046);
    @(posedge clk);             // E0
    #1;
    start8 = 1'b0;
    idle_cycles(2);             // after E2: RUN cycle 3
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1'b1;
    idle_cycles(1);             // across E3
    start8 = 1'b0;
    idle_cycles(5);             // after E8: DONE
    check("ign_done_pulse", {15'd0, done8}, 16'd1);
    start8 = 1'b1;
    idle_cycles(1);             // across E9 (DONE -> IDLE)
    start8 = 1'b0;
    check("ign_busy_after", {15'd0, busy8}, 16'd0);
    idle_cycles(3);
    check("ign_still_idle", {15'd0, busy8}, 16'd0);
    check("ign_one_done", 16'(done8_cnt - d0), 16'd1);
    check("ign_result", {7'd0, cout8, sum8}, 16'h0046);

    // Reset in the middle of RUN
    d0 = done8_cnt;
    a8 = 8'hFF;
    b8 = 8'h01;
    start8 = 1'b1;
    @(posedge clk);             // E0
    #1;
    start8 = 1'b0;
    idle_cycles(3);             // RUN cycle 4
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {15'd0, busy8}, 16'd0);
    check("mid_rst_done", {15'd0, done8}, 16'd0);
    check("mid_rst_result", {7'd0, cout8, sum8}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(12);
    check("post_rst_busy", {15'd0, busy8}, 16'd0);
    check("post_rst_no_done", 16'(done8_cnt - d0), 16'd0);
    add8(8'h01, 8'h02);

    // start held high: an operation every 10 cycles
    a8 = 8'h80;
    b8 = 8'h80;
    start8 = 1'b1;
    for (int n = 0; n < 3; n++) exp8_q.push_back(9'h100);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 20) start8 = 1'b0;
      check("stream_done", {15'd0, done8}, ((k % 10) == 8) ? 16'd1 : 16'd0);
    end
    check("stream_idle", {15'd0, busy8}, 16'd0);

    // A few random operands
    for (int n = 0; n < 3; n++) begin
      add8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // WIDTH=1 instance
    add1(1'b1, 1'b1);
    add1(1'b1, 1'b0);
    add1(1'b0, 1'b0);

    idle_cycles(2);
    check("sb8_drained", 16'(exp8_q.size()), 16'd0);
    check("sb1_drained", 16'(exp1_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
